// File: rtl/fp_norm_round_if.sv
// Handshake and data bundle between the FP adder's add/sub stage, the
// normalize/round stage and its consumer.
interface fp_norm_round_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [FRAC_W+1:0]       in_mant;
    logic [2:0]              in_grs;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_result;
    logic                    out_inexact;
    logic                    out_overflow;
    logic                    out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        input  in_ready, out_valid, out_result, out_inexact, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        output in_ready, out_valid, out_result, out_inexact, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_norm_round.sv
// Normalize + round-to-nearest-even + pack stage of the binary32 adder, 2-stage valid/ready pipe.
// Define FP_NORM_DENORM_EN for gradual underflow; default build flushes tiny results to zero.
module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_norm_round_if.slave io
);
    localparam int SW = FRAC_W + 1;
    localparam int RW = SW + 1;
    localparam int VW = FRAC_W + 3;
    localparam int XW = EXP_W + 2;
    localparam int LW = $clog2(VW + 1);
    localparam logic [XW-1:0] MAXE = XW'((1 << EXP_W) - 1);
    localparam logic [XW-1:0] ONE  = XW'(1);
    localparam logic [XW-1:0] TWO  = XW'(2);

    typedef struct packed {
        logic          sign;
        logic [XW-1:0] exp;
        logic [SW-1:0] sig;
        logic          g;
        logic          r;
        logic          s;
        logic          zero;
        logic          flush;
        logic          den;
    } s1_t;

    function automatic logic [LW-1:0] lzc(input logic [VW-1:0] v);
        lzc = LW'(VW);
        for (int i = 0; i < VW; i++)
            if (v[i]) lzc = LW'(VW - 1 - i);
    endfunction

    logic s1_valid;
    logic s2_adv;
    s1_t  s1_d;
    s1_t  s1_q;

    assign s2_adv      = !io.out_valid || io.out_ready;
    assign io.in_ready = !s1_valid || s2_adv;

    // Stage 1: normalize. Exponent math is XW bits wide so a negative
    // result after the cancellation shift shows up in the top bit.
    logic [VW-1:0] vec;
    logic [VW-1:0] shv;
    logic [LW-1:0] lz;
    logic [XW-1:0] ex;
    logic [XW-1:0] en;
    logic [XW-1:0] sh;

    always_comb begin
        s1_d      = '0;
        vec       = {io.in_mant[FRAC_W:0], io.in_grs[2:1]};
        lz        = lzc(vec);
        ex        = XW'(io.in_exp);
        en        = ex - XW'(lz);
        sh        = XW'(lz);
        shv       = '0;
        s1_d.sign = io.in_sign;
        if (io.in_mant[FRAC_W+1]) begin
            s1_d.exp = ex + ONE;
            s1_d.sig = io.in_mant[FRAC_W+1:1];
            s1_d.g   = io.in_mant[0];
            s1_d.r   = io.in_grs[2];
            s1_d.s   = io.in_grs[1] | io.in_grs[0];
        end else if (vec == '0) begin
            s1_d.zero = 1'b1;
        end else begin
            s1_d.exp = en;
`ifdef FP_NORM_DENORM_EN
            // Tiny result: only shift far enough to land on exponent 1,
            // which the packed format encodes as a zero field.
            if (en[XW-1] || en == '0) begin
                sh        = (ex == '0) ? '0 : ex - ONE;
                s1_d.exp  = '0;
                s1_d.den  = 1'b1;
            end
`else
            s1_d.flush = en[XW-1] || en == '0;
`endif
            shv      = vec << sh;
            s1_d.sig = shv[VW-1:2];
            s1_d.g   = shv[1];
            s1_d.r   = shv[0];
            s1_d.s   = io.in_grs[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (io.in_ready) begin
            s1_valid <= io.in_valid;
            if (io.in_valid) s1_q <= s1_d;
        end
    end

    // Stage 2: RNE round, exponent fix-up, exception packing.
    logic                  up;
    logic [RW-1:0]         rsum;
    logic [FRAC_W-1:0]     rfrac;
    logic [XW-1:0]         rexp;
    logic                  inx;
    logic                  ovf;
    logic                  unf;
    logic [EXP_W+FRAC_W:0] res;

    always_comb begin
        up    = s1_q.g & (s1_q.r | s1_q.s | s1_q.sig[0]);
        rsum  = {1'b0, s1_q.sig} + RW'(up);
        rfrac = rsum[FRAC_W-1:0];
        rexp  = s1_q.exp;
        if (rsum[SW]) begin
            rfrac = rsum[FRAC_W:1];
            rexp  = s1_q.exp + ONE;
        end
        // Denormals sit at exponent 1 once the hidden bit is set by rounding.
        if (s1_q.den) rexp = rsum[SW] ? TWO : (rsum[SW-1] ? ONE : '0);
        inx = s1_q.g | s1_q.r | s1_q.s;
        ovf = 1'b0;
        unf = 1'b0;
        res = {s1_q.sign, rexp[EXP_W-1:0], rfrac};
        if (s1_q.zero) begin
            res = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
            inx = 1'b0;
        end else if (s1_q.flush) begin
            res = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
            unf = 1'b1;
            inx = 1'b1;
        end else if (rexp >= MAXE) begin
            res = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf = 1'b1;
            inx = 1'b1;
        end else if (s1_q.den) begin
            unf = inx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid     <= 1'b0;
            io.out_result    <= '0;
            io.out_inexact   <= 1'b0;
            io.out_overflow  <= 1'b0;
            io.out_underflow <= 1'b0;
        end else if (s2_adv) begin
            io.out_valid <= s1_valid;
            if (s1_valid) begin
                io.out_result    <= res;
                io.out_inexact   <= inx;
                io.out_overflow  <= ovf;
                io.out_underflow <= unf;
            end
        end
    end
endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-addition normalize-and-round stage of the single-precision FP adder.
- Consumes the raw significand sum, exponent and guard/round/sticky bits from the add/subtract stage.
- Normalizes via right shift on carry-out, or via leading-zero count and left shift on cancellation. Then applies round-to-nearest-even and packs an IEEE-754 binary32 word.
- 2-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width. Significand is FRAC_W+2 bits: carry, hidden, fraction.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  stage can accept input
- in_sign  in  1  result sign
- in_exp  in  EXP_W  biased exponent of the unnormalized sum; hidden-bit position = bit FRAC_W
- in_mant  in  FRAC_W+2  {carry, hidden, fraction} raw sum
- in_grs  in  3  guard, round, sticky
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  packed {sign, exp, frac}
- out_inexact  out  1  any of the final g/r/s bits nonzero
- out_overflow  out  1  result saturated to infinity
- out_underflow  out  1  result flushed to zero (or denormal, see Optional Feature)

Behaviour:
- Reset: s1_valid=0, out_valid=0, all out_* data and flags 0; in_ready=1 one cycle after reset release. Reset mid-operation discards in-flight data.
- Handshake:
  - Transfer occurs when valid&ready are both high in the same cycle.
  - s2_adv = !out_valid | out_ready; in_ready = !s1_valid | s2_adv.
  - While out_valid & !out_ready: out_* stay stable; no loss, no duplication, order preserved.
- Latency: 2 cycles from accepted input to out_valid when unstalled. Throughput 1/cycle.
- Stage 1, normalize (exponent arithmetic in signed EXP_W+2 bits):
  - carry=1: right shift 1; g'=mant[0], r'=g, s'=r|s; exp+1.
  - carry=0, mant[FRAC_W+1:0]=0, g=r=0: exact zero; result ±0 with sign preserved, flags 0.
  - otherwise: lz = leading zeros of 26-bit {hidden, frac, g, r} (range 0..25); left shift that vector by lz, zeros in; s unchanged; exp - lz.
  - Normalized exp <= 0: flush to ±0; underflow=1; inexact=1.
- Stage 2, round (RNE):
  - up = g & (r | s | lsb).
  - Fraction increment carrying out of the hidden bit: significand = 1.0, exp+1.
  - Final exp >= 2^EXP_W-1: out_result = {sign, all-ones exp, 0} (infinity); overflow=1; inexact=1.
  - inexact = g|r|s for all non-exceptional results.
- Inputs with exponent field all-ones are not special-cased; they are treated as overflow. NaN/Inf bypass is upstream's job.

Optional Feature:
- Macro: FP_NORM_DENORM_EN.
- Defined: gradual underflow. When exp - lz <= 0, left shift is limited to max(in_exp-1, 0); exponent field = 0; result is denormal and rounded RNE normally. Rounding carry into the hidden bit yields exp=1. underflow=1 only when the denormal result is inexact.
- Undefined: flush-to-zero as in Behaviour.

Test Plan:
- mant=25'h1000000, exp=127, grs=000 -> 0x40000000 exactly 2 cycles after accept; all flags 0.
- mant=25'h0000001, exp=127, grs=000 (cancellation, lz=23) -> 0x34000000; mant=0, grs=000 -> 0x00000000; same with sign=1 -> 0x80000000.
- RNE:
  - mant=25'h0800001, grs=100 -> 0x3F800002, inexact=1.
  - mant=25'h0800000, grs=100 -> 0x3F800000, inexact=1.
  - mant=25'h0FFFFFF, grs=110 -> 0x40000000 (round carry).
- mant=25'h1000000, exp=254 -> 0x7F800000, overflow=1.
- mant=25'h0000001, exp=10:
  - without macro -> 0x00000000, underflow=1.
  - with FP_NORM_DENORM_EN -> 0x00000200, underflow=0.
- Backpressure: 4 back-to-back inputs, out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, out_result constant while stalled, all 4 results emitted in order once out_ready=1. Assert rst_n low mid-stream -> out_valid=0 immediately, no stale output after release.
